// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS datapath blocks used by the multiply/divide
// unit: MdOp encodings, the multiply/divide sequencer state enum and the
// iteration count.
// -----------------------------------------------------------------------------
package mips_pkg;

    // MdOpE encodings: bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // One iteration per operand bit.
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative 32-bit signed/unsigned multiply/divide unit holding the
// architectural HI/LO registers. Sits beside the execute stage; Busy lets the
// hazard unit stall MFHI/MFLO/MTHI/MTLO/MULT/DIV in decode until done.
//
// Ports
//   CLK       rising-edge clock
//   RST       asynchronous reset, active-low
//   StartE    start MULT/MULTU/DIV/DIVU (sampled only when idle)
//   MdOpE     operation select (see mips_pkg MD_* encodings)
//   SrcAE     forwarded rs: multiplicand / dividend / MTHI-MTLO data
//   SrcBE     forwarded rt: multiplier / divisor
//   HiWriteE  MTHI: HI <= SrcAE (idle only, loses to StartE)
//   LoWriteE  MTLO: LO <= SrcAE (idle only, loses to StartE)
//   Busy      operation in progress (decoded from the state register)
//   Hi, Lo    HI/LO registers
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int MD_ITER = mips_pkg::MD_ITER
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        StartE,
    input  logic [1:0]  MdOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        HiWriteE,
    input  logic        LoWriteE,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    import mips_pkg::*;

    localparam int CW = $clog2(MD_ITER);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] work_q, work_d;     // product, or {remainder, quotient}
    logic [31:0] a_q, a_d;           // |multiplicand|
    logic [31:0] b_q, b_d;           // |multiplier| (shifts) or |divisor|
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;  // negate product / quotient
    logic        neg_rem_q, neg_rem_d;  // remainder takes dividend's sign
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Shared negators: operand abs on entry, result correction in FIX.
    // The 64-bit product negation reuses the low-half negator; the high half
    // only needs the carry out of the low half (set when the low half is 0).
    logic        op_signed;
    logic [31:0] neg_a, neg_b, neg_lo, neg_hi, neg_hi_c;
    logic [31:0] a_abs, b_abs;

    always_comb begin
        op_signed = (MdOpE == MD_MULT) || (MdOpE == MD_DIV);
        neg_a     = -SrcAE;
        neg_b     = -SrcBE;
        a_abs     = (op_signed && SrcAE[31]) ? neg_a : SrcAE;
        b_abs     = (op_signed && SrcBE[31]) ? neg_b : SrcBE;
        neg_lo    = -work_q[31:0];
        neg_hi    = -work_q[63:32];
        neg_hi_c  = ~work_q[63:32] + {31'b0, (work_q[31:0] == 32'b0)};
    end

    // Datapath step helpers.
    logic [32:0] mul_sum;
    logic        div_fits;
    logic [31:0] div_rem;

    always_comb begin
        mul_sum  = {1'b0, work_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'b0)};
        // 33-bit trial: shifted partial remainder against the divisor.
        div_fits = work_q[63:31] >= {1'b0, b_q};
        div_rem  = work_q[62:31] - b_q;
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        a_d       = a_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                if (StartE) begin
                    a_d       = a_abs;
                    b_d       = b_abs;
                    cnt_d     = '0;
                    is_div_d  = MdOpE[1];
                    neg_res_d = op_signed && (SrcAE[31] ^ SrcBE[31]);
                    neg_rem_d = op_signed && SrcAE[31];
                    if (MdOpE[1]) begin
                        state_d = DIV;
                        work_d  = {32'b0, a_abs};
                    end else begin
                        state_d = MUL;
                        work_d  = 64'b0;
                    end
                end else begin
                    if (HiWriteE) hi_d = SrcAE;
                    if (LoWriteE) lo_d = SrcAE;
                end
            end
            MUL: begin
                // Accumulate into the high half, shift the product right.
                work_d = {mul_sum, work_q[31:1]};
                b_d    = b_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(MD_ITER - 1)) state_d = FIX;
            end
            DIV: begin
                if (div_fits) work_d = {div_rem, work_q[30:0], 1'b1};
                else          work_d = {work_q[62:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MD_ITER - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                if (is_div_q) begin
                    // Divide by zero leaves |dividend| as remainder; the
                    // remainder sign fix restores the original SrcAE.
                    if (b_q == 32'b0)   lo_d = 32'hFFFF_FFFF;
                    else if (neg_res_q) lo_d = neg_lo;
                    else                lo_d = work_q[31:0];
                    hi_d = neg_rem_q ? neg_hi : work_q[63:32];
                end else begin
                    hi_d = neg_res_q ? neg_hi_c : work_q[63:32];
                    lo_d = neg_res_q ? neg_lo   : work_q[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            a_q       <= a_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy = (state_q != IDLE);
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed bench for mul_div_unit. Stimulus pushes hand-computed HI/LO results
// into a scoreboard queue; a monitor pops and compares whenever Busy falls.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
    import mips_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        StartE = 1'b0;
    logic [1:0]  MdOpE = 2'b00;
    logic [31:0] SrcAE = 32'b0;
    logic [31:0] SrcBE = 32'b0;
    logic        HiWriteE = 1'b0;
    logic        LoWriteE = 1'b0;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    mul_div_unit dut (
        .CLK      (CLK),
        .RST      (RST),
        .StartE   (StartE),
        .MdOpE    (MdOpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .HiWriteE (HiWriteE),
        .LoWriteE (LoWriteE),
        .Busy     (Busy),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_total  = 0;
    int   n_passed = 0;

    // Architectural HI/LO the bench expects outside of FIX edges.
    logic [31:0] m_hi = 32'b0;
    logic [31:0] m_lo = 32'b0;

    localparam int M_NORMAL = 0;
    localparam int M_MTLO   = 1;   // LoWriteE alongside StartE
    localparam int M_INJECT = 2;   // StartE/MT pulses while busy
    localparam int M_ABORT  = 3;   // reset at iteration 10

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a falling Busy presents a result.
    logic busy_prev = 1'b0;
    always @(negedge CLK) begin
        if (!RST) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !Busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_hi"}, Hi, e.hi);
                    check({e.name, "_lo"}, Lo, e.lo);
                end
            end
            busy_prev = Busy;
        end
    end

    // Entered and left at a negedge with Busy low.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int mode);
        int n;
        StartE = 1'b1;
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        if (mode == M_MTLO) LoWriteE = 1'b1;
        if (mode != M_ABORT) sb.push_back('{name, ehi, elo});
        @(negedge CLK);
        StartE   = 1'b0;
        LoWriteE = 1'b0;
        SrcAE    = 32'hDEAD_BEEF;   // operands must already be latched
        SrcBE    = 32'h0BAD_F00D;
        check({name, "_busy"}, {31'b0, Busy}, 32'd1);
        check({name, "_hold_hi"}, Hi, m_hi);
        check({name, "_hold_lo"}, Lo, m_lo);
        n = 0;
        while (Busy && n < 100) begin
            n++;
            if (mode == M_INJECT && n == 10) begin
                StartE   = 1'b1;
                MdOpE    = MD_MULTU;
                SrcAE    = 32'd5;
                SrcBE    = 32'd5;
                HiWriteE = 1'b1;
                LoWriteE = 1'b1;
            end
            if (mode == M_INJECT && n == 11) begin
                StartE   = 1'b0;
                HiWriteE = 1'b0;
                LoWriteE = 1'b0;
            end
            if (mode == M_ABORT && n == 10) begin
                #2 RST = 1'b0;
                #1;
                check("abort_busy", {31'b0, Busy}, 32'd0);
                check("abort_hi", Hi, 32'd0);
                check("abort_lo", Lo, 32'd0);
                m_hi = 32'b0;
                m_lo = 32'b0;
                @(negedge CLK);
                #1 RST = 1'b1;
                @(negedge CLK);
                return;
            end
            @(negedge CLK);
        end
        check({name, "_busy_cycles"}, n, 32'd33);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_busy", {31'b0, Busy}, 32'd0);
        check("reset_hi", Hi, 32'd0);
        check("reset_lo", Lo, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        run_op("multu_7x6", MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, M_NORMAL);
        run_op("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, M_NORMAL);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, M_NORMAL);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, M_NORMAL);
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, M_NORMAL);
        run_op("divu_9_0", MD_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, M_NORMAL);
        run_op("div_m9_0", MD_DIV, 32'hFFFF_FFF7, 32'd0,
               32'hFFFF_FFF7, 32'hFFFF_FFFF, M_NORMAL);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, M_NORMAL);

        // MTHI / MTLO / both, single cycle in IDLE.
        HiWriteE = 1'b1; SrcAE = 32'h1234;
        @(negedge CLK);
        HiWriteE = 1'b0;
        check("mthi_hi", Hi, 32'h1234);
        check("mthi_lo", Lo, m_lo);
        m_hi = 32'h1234;
        LoWriteE = 1'b1; SrcAE = 32'h5678;
        @(negedge CLK);
        LoWriteE = 1'b0;
        check("mtlo_lo", Lo, 32'h5678);
        check("mtlo_hi", Hi, 32'h1234);
        HiWriteE = 1'b1; LoWriteE = 1'b1; SrcAE = 32'hA5A5_0F0F;
        @(negedge CLK);
        HiWriteE = 1'b0; LoWriteE = 1'b0;
        check("mtboth_hi", Hi, 32'hA5A5_0F0F);
        check("mtboth_lo", Lo, 32'hA5A5_0F0F);
        m_hi = 32'hA5A5_0F0F;
        m_lo = 32'hA5A5_0F0F;

        // Start wins over a simultaneous MTLO (hold check sees old LO).
        run_op("start_mtlo", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, M_MTLO);
        // Start/MT pulses while busy are ignored.
        run_op("busy_inject", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, M_INJECT);
        // Reset mid-operation, then a clean operation.
        run_op("abort", MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, M_ABORT);
        run_op("multu_2x3", MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, M_NORMAL);

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, attached beside the execute stage of the pipelined MIPS datapath. Takes operands after execute-stage forwarding, runs signed/unsigned MULT/DIV over multiple cycles, and raises `Busy` so the hazard unit can stall fetch/decode on MFHI/MFLO or a second start. HI/LO read ports feed the execute-stage result path for MFHI/MFLO.

## Interface
- `MD_ITER`, default 32: iteration count. Equals operand width; not intended to change.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous reset, active-low.
- `StartE`  in  1  start request from execute stage (MULT/MULTU/DIV/DIVU in E, not flushed).
- `MdOpE`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `SrcAE`  in  32  forwarded rs value (multiplicand / dividend / MTHI-MTLO data).
- `SrcBE`  in  32  forwarded rt value (multiplier / divisor).
- `HiWriteE`  in  1  MTHI: HI <= SrcAE.
- `LoWriteE`  in  1  MTLO: LO <= SrcAE.
- `Busy`  out  1  operation in progress.
- `Hi`  out  32  HI register.
- `Lo`  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX. `Busy` = (state != IDLE), decoded from the state register only.
- IDLE and `StartE`=1: latch operands into working registers and go to MUL (MdOpE[1]=0) or DIV (MdOpE[1]=1). Clear the iteration counter. Record result signs:
  - Signed ops take |SrcAE| and |SrcBE|.
  - MULT negates the 64-bit product when the operand signs differ.
  - DIV negates the quotient when the operand signs differ, and gives the remainder the sign of the dividend.
- MUL: one shift-add step per cycle on a 64-bit product register with a 32-bit multiplier register.
- DIV: one restoring-division step per cycle on a 64-bit remainder/quotient register with a 33-bit trial subtract.
- Leave MUL/DIV when the counter reaches `MD_ITER`-1, going to FIX.
- FIX: apply sign correction, write HI/LO, return to IDLE.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero, signed or unsigned: LO = 32'hFFFF_FFFF, HI = SrcAE as latched. No sign correction.
- DIV with 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0. Falls out of the unsigned magnitude path.
- MTHI/MTLO: act only in IDLE.
  - `StartE` in the same cycle has priority: the MT write is dropped.
  - `HiWriteE` and `LoWriteE` together write both registers.
- `StartE`, `HiWriteE`, `LoWriteE` while `Busy`: ignored. The hazard unit guarantees they are stalled, and the bench checks that they are ignored.
- `Hi`/`Lo` hold their old values for the whole operation and change only at the FIX edge.
- No abort input. A pipeline flush after the start does not cancel the operation.

## Timing
- Reset (RST low, async): state IDLE, `Busy`=0, `Hi`=0, `Lo`=0, working registers and counter cleared.
- Reset asserted mid-operation: same values, effective immediately. The partial result is discarded.
- Edge 0: `StartE` sampled in IDLE. `Busy` is high after edge 0.
- Edges 1..32: iterations.
- Edge 33: FIX. `Hi`/`Lo` hold the new result and `Busy` is low after edge 33.
- `Busy` is high for exactly 33 cycles.
- Back-to-back: a new `StartE` is accepted on edge 34 at the earliest, i.e. the first edge sampled with `Busy`=0.
- MTHI/MTLO: single cycle. Written on the sampling edge, visible the next cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package (`mips_pkg`) holds:
  - the MdOp encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`);
  - the state enum;
  - `MD_ITER`.
- Single module; no sub-module needed.
- Sign handling (abs on entry, negate in FIX) uses shared combinational negators inside the module.
- Hazard unit integration:
  - stall F/D while `Busy` and the decode-stage instruction is MFHI, MFLO, MTHI, MTLO, MULT or DIV;
  - flush E accordingly.

## Test plan
- Reset: `Hi`=`Lo`=0, `Busy`=0. MULTU 7×6: `Busy` high for 33 cycles, then HI=0, LO=42.
- MULT −3×5 (SrcAE=32'hFFFF_FFFD): HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1.
- MULTU 32'hFFFF_FFFF×32'hFFFF_FFFF: HI=32'hFFFF_FFFE, LO=32'h0000_0001.
- DIVU 100/7: LO=14, HI=2. DIV −7/2: LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIVU 9/0: LO=32'hFFFF_FFFF, HI=9.
- DIV 32'h8000_0000/32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- MTHI 32'h1234 in IDLE: `Hi`=32'h1234 next cycle.
- `StartE`+`LoWriteE` together: the start wins and LO is unchanged by the MTLO.
- `StartE` pulsed while `Busy`: ignored, and the first result is unaffected.
- RST low at iteration 10: immediate IDLE, `Busy`=0, `Hi`=`Lo`=0. A following MULTU 2×3 gives LO=6.
